// File: rtl/seq_arith_pkg.sv
// Types and defaults shared by the sequential repeated-add multiplier and
// repeated-subtract divider.
package seq_arith_pkg;

    localparam int SEQ_N = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: running remainder, latched divisor and quotient counter,
// with the >= compare and 2N-bit subtractor that drive the control FSM.
module div_datapath
    import seq_arith_pkg::*;
#(
    parameter int N = SEQ_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           ge,
    output logic           divisor_zero,
    output logic [2*N-1:0] quo,
    output logic [N-1:0]   rem_low
);

    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] rem_reg;
    logic [N-1:0]   dvs_reg;
    logic [2*N-1:0] quo_reg;
    logic [2*N-1:0] dvs_ext;

    assign dvs_ext      = {{N{1'b0}}, dvs_reg};
    assign ge           = (rem_reg >= dvs_ext);
    assign divisor_zero = (divisor == '0);
    assign quo          = quo_reg;
    // Once ge drops the remainder is below an N-bit divisor, so the low half is exact.
    assign rem_low      = rem_reg[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg <= '0;
            dvs_reg <= '0;
            quo_reg <= '0;
        end else if (load) begin
            rem_reg <= dividend;
            dvs_reg <= divisor;
            quo_reg <= '0;
        end else if (step) begin
            rem_reg <= rem_reg - dvs_ext;
            quo_reg <= quo_reg + ONE;
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider (2N-bit dividend / N-bit divisor) by repeated
// subtraction, with a start/ready/done handshake.
module seq_div
    import seq_arith_pkg::*;
#(
    parameter int N = SEQ_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    // state | meaning
    // IDLE  | ready for a new request
    // SUB   | subtract divisor while remainder >= divisor
    // DONE  | one-cycle done pulse, results valid
    div_state_t state, state_nxt;

    logic           load;
    logic           step;
    logic           capture;
    logic           ge;
    logic           divisor_zero;
    logic [2*N-1:0] quo;
    logic [N-1:0]   rem_low;

    div_datapath #(.N(N)) u_dp (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .dividend     (dividend),
        .divisor      (divisor),
        .ge           (ge),
        .divisor_zero (divisor_zero),
        .quo          (quo),
        .rem_low      (rem_low)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = divisor_zero ? DONE : SUB;
                end
            end
            SUB: begin
                if (ge) begin
                    step = 1'b1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // Results change only when an operation completes; they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            div_by_zero <= divisor_zero;
            if (divisor_zero) begin
                quotient  <= '1;
                remainder <= '0;
            end
        end else if (capture) begin
            quotient  <= quo;
            remainder <= rem_low;
        end
    end

endmodule
